// File: rtl/cache_ctrl.sv
// Two-way set-associative write-back/write-allocate data cache controller (2 ways x 16 sets, 256-bit lines).
// Define CACHE_STATS_EN to add the hit_cnt/miss_cnt statistics outputs.
module cache_ctrl (
  input  logic         clk,
  input  logic         rstn,
  input  logic         cpu_req_valid,
  output logic         cpu_req_ready,
  input  logic         cpu_we,
  input  logic [63:0]  cpu_addr,
  input  logic [63:0]  cpu_wdata,
  input  logic [7:0]   cpu_wmask,
  output logic         cpu_resp_valid,
  output logic [63:0]  cpu_rdata,
  output logic         mem_req,
  output logic         mem_we,
  output logic [63:0]  mem_addr,
  output logic [255:0] mem_wdata,
  input  logic [255:0] mem_rdata,
  input  logic         mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
`endif
);

  localparam int unsigned ADDR_WIDTH = 64;
  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned BANK_NUM   = 4;
  localparam int unsigned LINE_NUM   = 16;
  localparam int unsigned TAG_WIDTH  = ADDR_WIDTH - 9;

  typedef enum logic [1:0] {IDLE, COMPARE, WB, REFILL} state_t;

  state_t state;

  logic [TAG_WIDTH-1:0]                 tag_arr  [2][LINE_NUM];
  logic [BANK_NUM-1:0][DATA_WIDTH-1:0]  data_arr [2][LINE_NUM];
  logic [1:0][LINE_NUM-1:0]             valid_arr, dirty_arr, lru_arr;

  logic                 req_we;
  logic [TAG_WIDTH-1:0] req_tag;
  logic [3:0]           req_idx;
  logic [1:0]           req_off;
  logic [63:0]          req_wdata;
  logic [7:0]           req_wmask;
  logic                 victim;

  logic                 hit0, hit1, hit, hit_way, victim_sel;
  logic [63:0]          hit_word, store_word;
  logic                 unused_granule;

  assign unused_granule = ^cpu_addr[2:0];

  assign hit0    = valid_arr[0][req_idx] && (tag_arr[0][req_idx] == req_tag);
  assign hit1    = valid_arr[1][req_idx] && (tag_arr[1][req_idx] == req_tag);
  assign hit     = hit0 || hit1;
  assign hit_way = !hit0;
  assign hit_word = data_arr[hit_way][req_idx][req_off];

  // Invalid ways are filled first (way 0 preferred); otherwise the way whose lru bit is set.
  always_comb begin
    if (!valid_arr[0][req_idx])      victim_sel = 1'b0;
    else if (!valid_arr[1][req_idx]) victim_sel = 1'b1;
    else                             victim_sel = !lru_arr[0][req_idx];
  end

  always_comb begin
    store_word = hit_word;
    for (int unsigned i = 0; i < 8; i++) begin
      if (req_wmask[i]) store_word[i*8 +: 8] = req_wdata[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      valid_arr <= '0;
      dirty_arr <= '0;
      lru_arr   <= '0;
      req_we    <= 1'b0;
      req_tag   <= '0;
      req_idx   <= '0;
      req_off   <= '0;
      req_wdata <= '0;
      req_wmask <= '0;
      victim    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req_valid) begin
            req_we    <= cpu_we;
            req_tag   <= cpu_addr[63:9];
            req_idx   <= cpu_addr[8:5];
            req_off   <= cpu_addr[4:3];
            req_wdata <= cpu_wdata;
            req_wmask <= cpu_wmask;
            state     <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            lru_arr[hit_way][req_idx]  <= 1'b0;
            lru_arr[!hit_way][req_idx] <= 1'b1;
            if (req_we) dirty_arr[hit_way][req_idx] <= 1'b1;
            state <= IDLE;
          end else begin
            victim <= victim_sel;
            state  <= (valid_arr[victim_sel][req_idx] && dirty_arr[victim_sel][req_idx]) ? WB : REFILL;
          end
        end
        WB: begin
          if (mem_ack) state <= REFILL;
        end
        REFILL: begin
          if (mem_ack) begin
            valid_arr[victim][req_idx] <= 1'b1;
            dirty_arr[victim][req_idx] <= 1'b0;
            state <= COMPARE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data storage carry no reset; valid bits gate every use of them.
  always_ff @(posedge clk) begin
    if (state == COMPARE && hit && req_we) begin
      data_arr[hit_way][req_idx][req_off] <= store_word;
    end else if (state == REFILL && mem_ack) begin
      data_arr[victim][req_idx] <= mem_rdata;
      tag_arr[victim][req_idx]  <= req_tag;
    end
  end

  always_comb begin
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_rdata      = '0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    case (state)
      IDLE: cpu_req_ready = 1'b1;
      COMPARE: begin
        if (hit) begin
          cpu_resp_valid = 1'b1;
          cpu_rdata      = hit_word;
        end
      end
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_arr[victim][req_idx], req_idx, 5'b0};
        mem_wdata = data_arr[victim][req_idx];
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_idx, 5'b0};
      end
      default: ;
    endcase
  end

`ifdef CACHE_STATS_EN
  // The COMPARE re-entered after a refill must not count again.
  logic first_cmp;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      first_cmp <= 1'b0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      if (state == IDLE && cpu_req_valid) first_cmp <= 1'b1;
      else if (state == COMPARE)          first_cmp <= 1'b0;
      if (state == COMPARE && first_cmp) begin
        if (hit) hit_cnt  <= hit_cnt + 32'd1;
        else     miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed self-checking bench for cache_ctrl with a fixed-latency line memory responder.
`timescale 1ns/1ps
module tb_cache_ctrl;

  logic         clk;
  logic         rstn;
  logic         cpu_req_valid;
  logic         cpu_req_ready;
  logic         cpu_we;
  logic [63:0]  cpu_addr;
  logic [63:0]  cpu_wdata;
  logic [7:0]   cpu_wmask;
  logic         cpu_resp_valid;
  logic [63:0]  cpu_rdata;
  logic         mem_req;
  logic         mem_we;
  logic [63:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_ack;
`ifdef CACHE_STATS_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  localparam int MEM_LAT = 1;

  logic [255:0] mem_model [logic [63:0]];
  int           wb_cnt = 0;
  int           refill_cnt = 0;
  logic [63:0]  last_wb_addr = '0;
  logic [255:0] last_wb_data = '0;
  logic [63:0]  last_refill_addr = '0;
  logic         mem_hold = 1'b0;
  int           wait_cnt = 0;

  cache_ctrl dut (
    .clk            (clk),
    .rstn           (rstn),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_wmask      (cpu_wmask),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_rdata      (cpu_rdata),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, tests_failed=%0d", tests_failed);
    $fatal(1, "watchdog");
  end

  // Untouched memory line at address a: word b = {8'hD0+b, 24'h0, a[31:0]}.
  function automatic logic [255:0] dflt_line(input logic [63:0] a);
    logic [255:0] l;
    for (int unsigned b = 0; b < 4; b++) l[b*64 +: 64] = {8'(8'hD0 + b), 24'h0, a[31:0]};
    return l;
  endfunction

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (mem_req && !mem_hold) begin
        if (wait_cnt < MEM_LAT) wait_cnt++;
        else begin
          wait_cnt = 0;
          if (mem_we) begin
            mem_model[mem_addr] = mem_wdata;
            wb_cnt++;
            last_wb_addr = mem_addr;
            last_wb_data = mem_wdata;
          end else begin
            refill_cnt++;
            last_refill_addr = mem_addr;
            mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : dflt_line(mem_addr);
          end
          mem_ack = 1'b1;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Starts at a negedge; returns at the negedge showing the response. lat = negedges from accept to response.
  task automatic access(input logic we, input logic [63:0] a, input logic [63:0] wd,
                        input logic [7:0] wm, output logic [63:0] rd, output int lat);
    int n;
    cpu_req_valid = 1'b1;
    cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_wmask = wm;
    n = 0;
    while (!cpu_req_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    lat = 1;
    rd = '0;
    while (!cpu_resp_valid && lat < 200) begin @(negedge clk); lat++; end
    if (cpu_resp_valid) rd = cpu_rdata;
    else lat = -1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    cpu_req_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wmask = '0;
    repeat (2) @(negedge clk);
    tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_req_in_reset: got %b expected 0", mem_req); end
    rstn = 1'b1;
    @(negedge clk);
    tests_run++; if (cpu_req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", cpu_req_ready); end
    tests_run++; if (cpu_resp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_valid: got %b expected 0", cpu_resp_valid); end
    tests_run++; if (cpu_rdata !== 64'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h expected 0", cpu_rdata); end
    tests_run++; if ({mem_req, mem_we} !== 2'b00) begin tests_failed++; $display("FAIL reset_mem_req_we: got %b expected 00", {mem_req, mem_we}); end
    tests_run++; if (mem_addr !== 64'h0) begin tests_failed++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    tests_run++; if (mem_wdata !== 256'h0) begin tests_failed++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
`ifdef CACHE_STATS_EN
    tests_run++; if ({hit_cnt, miss_cnt} !== 64'h0) begin tests_failed++; $display("FAIL reset_counters: got %h/%h expected 0/0", hit_cnt, miss_cnt); end
`endif
  endtask

  task automatic test_clean_miss_hit;
    logic [63:0] rd; int lat; int r0; int w0;
    r0 = refill_cnt; w0 = wb_cnt;
    access(1'b0, 64'h1000, '0, '0, rd, lat);
    tests_run++; if (lat !== 4) begin tests_failed++; $display("FAIL miss_latency: got %0d expected 4", lat); end
    tests_run++; if (rd !== 64'hD000_0000_0000_1000) begin tests_failed++; $display("FAIL miss_rdata: got %h expected D000000000001000", rd); end
    tests_run++; if (last_refill_addr !== 64'h1000 || refill_cnt != r0 + 1 || wb_cnt != w0) begin tests_failed++; $display("FAIL miss_refill: got addr %h refills %0d wbs %0d expected 1000 1 0", last_refill_addr, refill_cnt - r0, wb_cnt - w0); end
    r0 = refill_cnt;
    access(1'b0, 64'h1018, '0, '0, rd, lat);
    tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL hit_latency: got %0d expected 1", lat); end
    tests_run++; if (rd !== 64'hD300_0000_0000_1000) begin tests_failed++; $display("FAIL hit_rdata: got %h expected D300000000001000", rd); end
    tests_run++; if (refill_cnt != r0) begin tests_failed++; $display("FAIL hit_no_mem: got %0d refills expected 0", refill_cnt - r0); end
  endtask

  task automatic test_store_merge;
    logic [63:0] rd; int lat;
    access(1'b1, 64'h1008, 64'hAABBCCDD_11223344, 8'h0F, rd, lat);
    tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL store_hit_latency: got %0d expected 1", lat); end
    access(1'b0, 64'h1008, '0, '0, rd, lat);
    tests_run++; if (rd !== 64'hD100_0000_1122_3344) begin tests_failed++; $display("FAIL store_merge: got %h expected D100000011223344", rd); end
  endtask

  task automatic test_dirty_wb;
    logic [63:0] rd; int lat; int w0; int r0;
    access(1'b0, 64'h2000, '0, '0, rd, lat);
    tests_run++; if (lat !== 4 || rd !== 64'hD000_0000_0000_2000) begin tests_failed++; $display("FAIL fill_way1: got lat %0d data %h expected 4 D000000000002000", lat, rd); end
    access(1'b0, 64'h2000, '0, '0, rd, lat);
    w0 = wb_cnt; r0 = refill_cnt;
    access(1'b0, 64'h3000, '0, '0, rd, lat);
    tests_run++; if (lat !== 7) begin tests_failed++; $display("FAIL dirty_miss_latency: got %0d expected 7", lat); end
    tests_run++; if (wb_cnt != w0 + 1 || last_wb_addr !== 64'h1000) begin tests_failed++; $display("FAIL wb_addr: got %h (%0d wbs) expected 1000 (1)", last_wb_addr, wb_cnt - w0); end
    tests_run++;
    if (last_wb_data !== {64'hD300_0000_0000_1000, 64'hD200_0000_0000_1000, 64'hD100_0000_1122_3344, 64'hD000_0000_0000_1000}) begin
      tests_failed++; $display("FAIL wb_data: got %h expected modified 0x1000 line", last_wb_data);
    end
    tests_run++; if (refill_cnt != r0 + 1 || last_refill_addr !== 64'h3000 || rd !== 64'hD000_0000_0000_3000) begin tests_failed++; $display("FAIL dirty_refill: got addr %h data %h expected 3000 D000000000003000", last_refill_addr, rd); end
    access(1'b0, 64'h2000, '0, '0, rd, lat);
    tests_run++; if (lat !== 1 || rd !== 64'hD000_0000_0000_2000) begin tests_failed++; $display("FAIL mru_kept: got lat %0d data %h expected 1 D000000000002000", lat, rd); end
  endtask

  task automatic test_clean_evict;
    logic [63:0] rd; int lat; int w0;
    w0 = wb_cnt;
    access(1'b0, 64'h4000, '0, '0, rd, lat);
    tests_run++; if (lat !== 4 || wb_cnt != w0) begin tests_failed++; $display("FAIL clean_evict: got lat %0d wbs %0d expected 4 0", lat, wb_cnt - w0); end
    access(1'b0, 64'h2008, '0, '0, rd, lat);
    tests_run++; if (lat !== 1 || rd !== 64'hD100_0000_0000_2000) begin tests_failed++; $display("FAIL mru_hit: got lat %0d data %h expected 1 D100000000002000", lat, rd); end
    access(1'b0, 64'h3010, '0, '0, rd, lat);
    tests_run++; if (lat !== 4 || rd !== 64'hD200_0000_0000_3000 || wb_cnt != w0) begin tests_failed++; $display("FAIL lru_evicted: got lat %0d data %h expected 4 D200000000003000", lat, rd); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] rd; int lat;
    access(1'b0, 64'h3008, '0, '0, rd, lat);
    tests_run++; if (lat !== 1 || rd !== 64'hD100_0000_0000_3000) begin tests_failed++; $display("FAIL b2b_first: got lat %0d data %h expected 1 D100000000003000", lat, rd); end
    @(negedge clk);
    tests_run++; if ({cpu_resp_valid, cpu_req_ready} !== 2'b01 || cpu_rdata !== 64'h0) begin tests_failed++; $display("FAIL resp_pulse: got valid/ready %b rdata %h expected 01 0", {cpu_resp_valid, cpu_req_ready}, cpu_rdata); end
    access(1'b1, 64'h2010, 64'h0123_4567_89AB_CDEF, 8'hFF, rd, lat);
    access(1'b1, 64'h2010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h80, rd, lat);
    access(1'b0, 64'h2010, '0, '0, rd, lat);
    tests_run++; if (lat !== 1 || rd !== 64'hFF23_4567_89AB_CDEF) begin tests_failed++; $display("FAIL mask_store: got lat %0d data %h expected 1 FF23456789ABCDEF", lat, rd); end
  endtask

  task automatic test_reset_mid;
    logic [63:0] rd; int lat; int n; int resp_seen; int r0;
    mem_hold = 1'b1;
    cpu_req_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h5000; cpu_wdata = '0; cpu_wmask = '0;
    n = 0;
    while (!mem_req && n < 50) begin @(negedge clk); n++; if (!cpu_req_ready) cpu_req_valid = 1'b0; end
    tests_run++; if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 64'h5000) begin tests_failed++; $display("FAIL refill_pending: got req/we %b addr %h expected 10 5000", {mem_req, mem_we}, mem_addr); end
    rstn = 1'b0;
    cpu_req_valid = 1'b0;
    #1;
    tests_run++; if (mem_req !== 1'b0 || mem_addr !== 64'h0) begin tests_failed++; $display("FAIL reset_drops_req: got req %b addr %h expected 0 0", mem_req, mem_addr); end
    @(negedge clk);
    rstn = 1'b1;
    mem_hold = 1'b0;
    resp_seen = 0;
    repeat (4) begin @(negedge clk); if (cpu_resp_valid) resp_seen++; end
    tests_run++; if (resp_seen != 0) begin tests_failed++; $display("FAIL no_resp_after_reset: got %0d responses expected 0", resp_seen); end
`ifdef CACHE_STATS_EN
    tests_run++; if ({hit_cnt, miss_cnt} !== 64'h0) begin tests_failed++; $display("FAIL mid_reset_counters: got %h/%h expected 0/0", hit_cnt, miss_cnt); end
`endif
    r0 = refill_cnt;
    access(1'b0, 64'h1000, '0, '0, rd, lat);
    tests_run++; if (lat !== 4 || refill_cnt != r0 + 1) begin tests_failed++; $display("FAIL miss_after_reset: got lat %0d refills %0d expected 4 1", lat, refill_cnt - r0); end
    tests_run++; if (rd !== 64'hD000_0000_0000_1000) begin tests_failed++; $display("FAIL wb_line_reloaded: got %h expected D000000000001000", rd); end
  endtask

`ifdef CACHE_STATS_EN
  task automatic test_stats;
    logic [63:0] rd; int lat;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    access(1'b0, 64'h1000, '0, '0, rd, lat);
    access(1'b0, 64'h1020, '0, '0, rd, lat);
    access(1'b0, 64'h1040, '0, '0, rd, lat);
    access(1'b0, 64'h1008, '0, '0, rd, lat);
    access(1'b1, 64'h1028, 64'h1, 8'h01, rd, lat);
    access(1'b0, 64'h1048, '0, '0, rd, lat);
    access(1'b0, 64'h1000, '0, '0, rd, lat);
    access(1'b0, 64'h1010, '0, '0, rd, lat);
    @(negedge clk);
    tests_run++; if (miss_cnt !== 32'd3) begin tests_failed++; $display("FAIL miss_cnt: got %0d expected 3", miss_cnt); end
    tests_run++; if (hit_cnt !== 32'd5) begin tests_failed++; $display("FAIL hit_cnt: got %0d expected 5", hit_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_miss_hit();
    test_store_merge();
    test_dirty_wb();
    test_clean_evict();
    test_back_to_back();
    test_reset_mid();
`ifdef CACHE_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Two-way set-associative, write-back, write-allocate data cache controller built on the `CACHEStruct` line format. It owns the tag/data array (2 ways × 16 sets of `CacheLine`) and serves single 64-bit CPU accesses. It sequences hit/miss handling, LRU victim selection, dirty writeback and line refill over a 256-bit line-wide memory handshake. It sits between the core's load/store unit and the memory/bus interface.

## Interface
Geometry is fixed by `CACHEStruct` localparams, with no overrides:
- `ADDR_WIDTH`, 64, address width; tag = addr[63:9] (55 bits), index = addr[8:5], offset (bank) = addr[4:3], granule = addr[2:0]
- `DATA_WIDTH`, 64, CPU word width
- `BANK_NUM`, 4, words per line (line = 256 bits)
- `LINE_NUM`, 16, sets per way

Ports:
- `clk` in 1: single clock, rising edge
- `rstn` in 1: asynchronous, active-low reset
- `cpu_req_valid` in 1: CPU request present
- `cpu_req_ready` out 1: controller can accept (IDLE only)
- `cpu_we` in 1: 1 = store, 0 = load
- `cpu_addr` in 64: byte address; granule bits ignored
- `cpu_wdata` in 64: store data
- `cpu_wmask` in 8: store byte enables
- `cpu_resp_valid` out 1: one-cycle completion pulse
- `cpu_rdata` out 64: load data, valid with `cpu_resp_valid`
- `mem_req` out 1: memory transaction request, held until ack
- `mem_we` out 1: 1 = writeback, 0 = refill
- `mem_addr` out 64: line-aligned address ([4:0] = 0)
- `mem_wdata` out 256: victim line data
- `mem_rdata` in 256: refill data, sampled on ack
- `mem_ack` in 1: one-cycle completion, meaningful only while `mem_req` = 1

## Operation
- States: IDLE, COMPARE, WB, REFILL.
- **IDLE**
  - `cpu_req_ready` = 1.
  - On valid & ready: latch `cpu_we`/addr/wdata/wmask and go to COMPARE.
- **COMPARE**
  - hit = valid & tag match in either way.
  - On hit:
    - Assert `cpu_resp_valid`.
    - Load: drive `cpu_rdata` = bank[offset].
    - Store: merge `cpu_wdata` into bank[offset] per `cpu_wmask` and set dirty = 1.
    - Update LRU and return to IDLE.
  - On miss: select the victim. If victim valid & dirty, go to WB; otherwise go to REFILL.
- **WB**
  - `mem_req` = 1, `mem_we` = 1.
  - `mem_addr` = {victim.tag, index, 5'b0}; `mem_wdata` = victim.data.
  - On `mem_ack`, go to REFILL.
- **REFILL**
  - `mem_req` = 1, `mem_we` = 0, `mem_addr` = {req tag, index, 5'b0}.
  - On `mem_ack`: write victim way with data = `mem_rdata`, tag = req tag, valid = 1, dirty = 0.
  - Then return to COMPARE, which now hits and completes the access, including store merge.
- **Victim selection**
  - First invalid way, way 0 preferred.
  - If both ways are valid, pick the way with lru = 1.
- **LRU**
  - On every hit in way w: line[w].lru ← 0 and line[~w].lru ← 1.
  - A refill alone does not update LRU; the following COMPARE hit does.
- Memory-side outputs are 0 when `mem_req` = 0.
- `cpu_rdata` is 0 when `cpu_resp_valid` = 0.

## Timing
- Reset (async, `rstn` = 0):
  - State = IDLE.
  - All valid/dirty/lru = 0.
  - `cpu_req_ready` = 1 after deassertion; `cpu_resp_valid` = 0, `cpu_rdata` = 0.
  - `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - Data/tag arrays need not be cleared.
- Reset mid-transaction: the in-flight memory request is dropped immediately. The pending CPU request is discarded with no response.
- Hit latency: accept at cycle N, `cpu_resp_valid` at N+1. The next accept is possible at N+2.
- Clean miss:
  - Accept N; COMPARE N+1.
  - `mem_req` (refill) from N+2 until the ack cycle A.
  - Response at A+1.
- Dirty miss:
  - WB from N+2 to ack A1; REFILL from A1+1 to ack A2; response at A2+1.
- `mem_req` deasserts or switches type the cycle after ack. No back-to-back reuse of the same ack.
- `mem_ack` while `mem_req` = 0 is ignored.
- `cpu_req_valid` outside IDLE is ignored (ready = 0). The CPU must hold its request until accepted.

## Configuration
- `CACHE_STATS_EN` defined:
  - Adds outputs `hit_cnt` out 32 and `miss_cnt` out 32, both reset to 0 and wrapping modulo 2^32.
  - Counts are taken only on the first COMPARE of each request. The post-refill COMPARE is not counted as a hit.
- `CACHE_STATS_EN` undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- After reset, load 0x1000 → REFILL `mem_addr` = 0x1000, ack with line {D3,D2,D1,D0} → `cpu_rdata` = D0; load 0x1018 → hit in 1 cycle, `cpu_rdata` = D3, no `mem_req`.
- Store 0x1008, wdata 0xAABBCCDD_11223344, wmask 0x0F → hit; a subsequent load 0x1008 returns upper 32 bits of D1 : 0x11223344.
- Fill set 0 with 0x1000 (dirty) and 0x2000, touch 0x2000, then load 0x3000 → WB `mem_addr` = 0x1000 with the modified line, then REFILL 0x3000; a subsequent load 0x2000 hits.
- Set 0 holds two clean lines; a third tag miss → no WB, only REFILL; LRU victim replaced; the MRU line still hits.
- Assert `rstn` = 0 during REFILL with `mem_req` = 1 → `mem_req` = 0 immediately; after release, a load to the same address misses again. With `CACHE_STATS_EN`: counters = 0.
- With `CACHE_STATS_EN`: 3 misses + 5 hits → `miss_cnt` = 3, `hit_cnt` = 5.
